// File: rtl/apb_cmd_master_if.sv
// -----------------------------------------------------------------------------
// apb_cmd_master_if
// Groups the signals of apb_cmd_master into one bundle: the command channel
// from the sequencer, the response channel back to it, the busy flag and the
// APB4 master bus towards the interconnect.
//
// Signals:
//   cmd_valid/cmd_ready        command handshake (sequencer -> master)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready        response handshake (master -> sequencer)
//   rsp_rdata/err/timeout      response payload
//   busy                       master has queued or in-flight work
//   PSEL..PSTRB                APB request signals driven by the master
//   PREADY/PRDATA/PSLVERR      APB completion signals driven by the slave
//
// Modports:
//   master  the apb_cmd_master side
//   slave   the environment side (sequencer plus APB slave)
// -----------------------------------------------------------------------------
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_strb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                rsp_timeout;

  logic                busy;

  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic                PREADY;
  logic [DATA_W-1:0]   PRDATA;
  logic                PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output busy,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  busy,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
// APB4 master driven from a command FIFO. Each queued command is executed as
// one SETUP/ACCESS transfer; its result (read data, slave error or timeout) is
// returned through a single-entry response register with valid/ready.
//
// Ports:
//   PCLK    clock, everything on the rising edge
//   PRESET  synchronous active-high reset
//   bus     apb_cmd_master_if.master: command channel, response channel,
//           busy flag and the APB4 master bus
//
// Parameters:
//   ADDR_W, DATA_W  address / data widths (DATA_W multiple of 8, 8..64)
//   FIFO_DEPTH      command FIFO entries (power of two, >= 2)
//   TIMEOUT         max ACCESS cycles before abort, 0 disables the abort
// -----------------------------------------------------------------------------
module apb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_cmd_master_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] { IDLE, SETUP, ACCESS } state_t;

  state_t r_state;
  state_t w_nextState;

  logic              r_fifoWrite [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifoAddr  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoWdata [FIFO_DEPTH];
  logic [STRB_W-1:0] r_fifoStrb  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_readyEn;

  logic [WAIT_W-1:0] r_waitCnt;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;

  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;
  logic              r_rspTimeout;

  logic w_cmdReady;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_start;
  logic w_timeout;
  logic w_done;
  logic w_psel;
  logic w_penable;
  logic w_busy;

  // r_readyEn holds cmd_ready low for the reset cycle itself, so every output
  // reads 0 while PRESET is being applied. A full FIFO refuses a push even
  // when a pop happens on the same edge.
  assign w_cmdReady = r_readyEn && (r_count != CNT_FULL);
  assign w_push     = bus.cmd_valid && w_cmdReady;
  assign w_empty    = (r_count == '0);

  // A transfer may only start while the response slot is free or draining,
  // which guarantees a completion never overwrites an unread response.
  assign w_start   = (r_state == IDLE) && !w_empty && (!r_rspValid || bus.rsp_ready);
  assign w_timeout = (TIMEOUT != 0) && !bus.PREADY && (r_waitCnt == WAIT_LAST);
  assign w_done    = (r_state == ACCESS) && (bus.PREADY || w_timeout);
  assign w_pop     = w_done;

  // Command storage: plain array, no reset needed since the count gates it.
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_fifoWrite[r_wrPtr] <= bus.cmd_write;
      r_fifoAddr[r_wrPtr]  <= bus.cmd_addr;
      r_fifoWdata[r_wrPtr] <= bus.cmd_wdata;
      r_fifoStrb[r_wrPtr]  <= bus.cmd_strb;
    end
  end

  // FIFO pointers and occupancy count. The head entry stays in the FIFO for
  // the whole transfer and is popped only when the transfer completes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_readyEn <= 1'b0;
    end else begin
      r_readyEn <= 1'b1;
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next-state logic: SETUP always lasts one cycle, ACCESS until PREADY
  // or the wait-state limit.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = SETUP;
      SETUP:   w_nextState = ACCESS;
      ACCESS:  if (w_done) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_psel    = (r_state != IDLE);
    w_penable = (r_state == ACCESS);
    w_busy    = (r_state != IDLE) || !w_empty;
  end

  // APB address/control: captured from the FIFO head when a transfer starts
  // and held unchanged until the next start. Reads never drive strobes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_start) begin
      r_pwrite <= r_fifoWrite[r_rdPtr];
      r_paddr  <= r_fifoAddr[r_rdPtr];
      r_pwdata <= r_fifoWdata[r_rdPtr];
      r_pstrb  <= r_fifoWrite[r_rdPtr] ? r_fifoStrb[r_rdPtr] : '0;
    end
  end

  // Wait-state counter: counts ACCESS cycles with PREADY low, cleared at the
  // start of every transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_waitCnt <= '0;
    end else if (w_start) begin
      r_waitCnt <= '0;
    end else if ((r_state == ACCESS) && !bus.PREADY) begin
      r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end
  end

  // Response register. PREADY wins over the timeout on the same cycle; the
  // slave's PRDATA/PSLVERR only matter when PREADY is high.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
    end else if (w_done) begin
      r_rspValid   <= 1'b1;
      r_rspRdata   <= (bus.PREADY && !r_pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
      r_rspErr     <= bus.PREADY ? bus.PSLVERR : 1'b1;
      r_rspTimeout <= !bus.PREADY;
    end else if (r_rspValid && bus.rsp_ready) begin
      r_rspValid   <= 1'b0;
    end
  end

  assign bus.cmd_ready   = w_cmdReady;
  assign bus.rsp_valid   = r_rspValid;
  assign bus.rsp_rdata   = r_rspRdata;
  assign bus.rsp_err     = r_rspErr;
  assign bus.rsp_timeout = r_rspTimeout;
  assign bus.busy        = w_busy;
  assign bus.PSEL        = w_psel;
  assign bus.PENABLE     = w_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.PSTRB       = r_pstrb;
endmodule

// File: tb/tb_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed scenarios with literal expectations followed by randomized traffic.
// A transaction-level model (command queue, cycle index within the current
// transfer, response slot) predicts every DUT output and is compared on each
// falling edge once the first reset has been seen.
// -----------------------------------------------------------------------------
module tb_apb_cmd_master;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int STRB_W     = DATA_W / 8;
  localparam logic [31:0] ECHO_KEY = 32'hA5A5_0F0F;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  bit   echoMode = 1'b0;

  apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the queue holds every accepted command until its transfer
  // finishes; mTxCycle is 0 for the SETUP cycle and k for the k-th ACCESS cycle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  cmd_t              mQ[$];
  cmd_t              mCmd;
  bit                mValid = 1'b0;
  bit                mReadyEn, mActive, mRspValid, mRspErr, mRspTo, mPwrite;
  bit                mPush, mStart;
  int                mTxCycle;
  logic [ADDR_W-1:0] mPaddr;
  logic [DATA_W-1:0] mPwdata, mRspRdata;
  logic [STRB_W-1:0] mPstrb;

  always @(negedge PCLK) begin
    if (mValid) begin
      checkOutput("cmd_ready",   64'(bus.cmd_ready),   64'(mReadyEn && (mQ.size() != FIFO_DEPTH)));
      checkOutput("busy",        64'(bus.busy),        64'(mActive || (mQ.size() != 0)));
      checkOutput("PSEL",        64'(bus.PSEL),        64'(mActive));
      checkOutput("PENABLE",     64'(bus.PENABLE),     64'(mActive && (mTxCycle >= 1)));
      checkOutput("PWRITE",      64'(bus.PWRITE),      64'(mPwrite));
      checkOutput("PADDR",       64'(bus.PADDR),       64'(mPaddr));
      checkOutput("PWDATA",      64'(bus.PWDATA),      64'(mPwdata));
      checkOutput("PSTRB",       64'(bus.PSTRB),       64'(mPstrb));
      checkOutput("rsp_valid",   64'(bus.rsp_valid),   64'(mRspValid));
      checkOutput("rsp_rdata",   64'(bus.rsp_rdata),   64'(mRspRdata));
      checkOutput("rsp_err",     64'(bus.rsp_err),     64'(mRspErr));
      checkOutput("rsp_timeout", 64'(bus.rsp_timeout), 64'(mRspTo));
    end

    // Advance the model by the rising edge that follows, using the inputs
    // that are stable across it.
    if (PRESET) begin
      mQ.delete();
      mValid    = 1'b1;
      mReadyEn  = 1'b0;
      mActive   = 1'b0;
      mTxCycle  = 0;
      mPwrite   = 1'b0;
      mPaddr    = '0;
      mPwdata   = '0;
      mPstrb    = '0;
      mRspValid = 1'b0;
      mRspRdata = '0;
      mRspErr   = 1'b0;
      mRspTo    = 1'b0;
    end else if (mValid) begin
      mStart = !mActive && (mQ.size() != 0) && (!mRspValid || bus.rsp_ready);
      mPush  = bus.cmd_valid && mReadyEn && (mQ.size() != FIFO_DEPTH);
      if (mRspValid && bus.rsp_ready) mRspValid = 1'b0;
      if (mActive && (mTxCycle >= 1)) begin
        if (bus.PREADY) begin
          mRspValid = 1'b1;
          mRspErr   = bus.PSLVERR;
          mRspTo    = 1'b0;
          mRspRdata = (!mPwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
          mActive   = 1'b0;
          void'(mQ.pop_front());
        end else if ((TIMEOUT > 0) && (mTxCycle == TIMEOUT)) begin
          mRspValid = 1'b1;
          mRspErr   = 1'b1;
          mRspTo    = 1'b1;
          mRspRdata = '0;
          mActive   = 1'b0;
          void'(mQ.pop_front());
        end else begin
          mTxCycle++;
        end
      end else if (mActive) begin
        mTxCycle = 1;
      end else if (mStart) begin
        mActive  = 1'b1;
        mTxCycle = 0;
        mPwrite  = mQ[0].write;
        mPaddr   = mQ[0].addr;
        mPwdata  = mQ[0].wdata;
        mPstrb   = mQ[0].write ? mQ[0].strb : '0;
      end
      if (mPush) begin
        mCmd.write = bus.cmd_write;
        mCmd.addr  = bus.cmd_addr;
        mCmd.wdata = bus.cmd_wdata;
        mCmd.strb  = bus.cmd_strb;
        mQ.push_back(mCmd);
      end
      mReadyEn = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge PCLK);
    #1;
    if (echoMode) bus.PRDATA = bus.PADDR ^ ECHO_KEY;
  endtask

  task automatic sendCmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
    checkOutput("accept_ready", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(found), 64'(1));
  endtask

  // Follows one transfer from accept to completion, counting ACCESS cycles.
  // PREADY is raised once the readyAt-th ACCESS cycle is observed (0 = never).
  task automatic runAccess(input int readyAt, output int accCnt, output bit strbBad);
    bit seenSel = 1'b0;
    accCnt  = 0;
    strbBad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.PSEL) seenSel = 1'b1;
      if (bus.PSEL && (bus.PSTRB != '0)) strbBad = 1'b1;
      if (bus.PENABLE) accCnt++;
      if (!bus.PSEL && seenSel) break;
      if ((readyAt != 0) && (accCnt == readyAt)) bus.PREADY = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int readyBias);
    bus.cmd_valid = ($urandom_range(0, 99) < 60);
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = ADDR_W'($urandom);
    bus.cmd_wdata = DATA_W'($urandom);
    bus.cmd_strb  = STRB_W'($urandom);
    bus.rsp_ready = ($urandom_range(0, 99) < 70);
    bus.PREADY    = ($urandom_range(0, 99) < readyBias);
    bus.PSLVERR   = ($urandom_range(0, 99) < 15);
    bus.PRDATA    = DATA_W'($urandom);
    PRESET        = ($urandom_range(0, 999) < 3);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int  accCnt;
  bit  strbBad;
  int  nAcc;
  int  got;
  bit  acc;
  bit  seen;
  int  biasTable [6] = '{70, 30, 3, 90, 50, 3};

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
    PRESET        = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("reset_psel",      64'(bus.PSEL),      64'(0));
    checkOutput("reset_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("reset_busy",      64'(bus.busy),      64'(0));
    PRESET = 1'b0;
    tick();
    checkOutput("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));

    // Write with zero wait states: SETUP, ACCESS, response three cycles after accept
    $display("[TB] write latency");
    sendCmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checkOutput("wr_e0_psel", 64'(bus.PSEL), 64'(0));
    tick();
    checkOutput("wr_setup_psel",    64'(bus.PSEL),    64'(1));
    checkOutput("wr_setup_penable", 64'(bus.PENABLE), 64'(0));
    checkOutput("wr_setup_paddr",   64'(bus.PADDR),   64'(32'h10));
    checkOutput("wr_setup_pwdata",  64'(bus.PWDATA),  64'(32'hDEADBEEF));
    checkOutput("wr_setup_pstrb",   64'(bus.PSTRB),   64'(4'hF));
    tick();
    checkOutput("wr_access_psel",    64'(bus.PSEL),    64'(1));
    checkOutput("wr_access_penable", 64'(bus.PENABLE), 64'(1));
    checkOutput("wr_access_pwdata",  64'(bus.PWDATA),  64'(32'hDEADBEEF));
    tick();
    checkOutput("wr_done_psel",  64'(bus.PSEL),      64'(0));
    checkOutput("wr_rsp_valid",  64'(bus.rsp_valid), 64'(1));
    checkOutput("wr_rsp_err",    64'(bus.rsp_err),   64'(0));
    checkOutput("wr_rsp_rdata",  64'(bus.rsp_rdata), 64'(0));
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("wr_rsp_drained", 64'(bus.rsp_valid), 64'(0));

    // Read with three wait states
    $display("[TB] read with wait states");
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h12345678;
    sendCmd(1'b0, 32'h20, 32'h5555AAAA, 4'hF);
    runAccess(4, accCnt, strbBad);
    checkOutput("rd_access_cycles", 64'(accCnt),        64'(4));
    checkOutput("rd_pstrb_zero",    64'(strbBad),       64'(0));
    checkOutput("rd_rsp_valid",     64'(bus.rsp_valid), 64'(1));
    checkOutput("rd_rsp_rdata",     64'(bus.rsp_rdata), 64'(32'h12345678));
    checkOutput("rd_rsp_err",       64'(bus.rsp_err),   64'(0));
    tick();

    // Slave error on a read
    $display("[TB] slave error");
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hCAFEF00D;
    sendCmd(1'b0, 32'h30, 32'h0, 4'h0);
    waitRsp("slverr_rsp_wait", 10);
    checkOutput("slverr_err",     64'(bus.rsp_err),     64'(1));
    checkOutput("slverr_timeout", 64'(bus.rsp_timeout), 64'(0));
    checkOutput("slverr_rdata",   64'(bus.rsp_rdata),   64'(0));
    bus.PSLVERR = 1'b0;
    tick();

    // Timeout with PREADY tied low
    $display("[TB] timeout");
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0BADBEEF;
    sendCmd(1'b0, 32'h40, 32'h0, 4'h0);
    runAccess(0, accCnt, strbBad);
    checkOutput("to_access_cycles", 64'(accCnt),          64'(16));
    checkOutput("to_rsp_err",       64'(bus.rsp_err),     64'(1));
    checkOutput("to_rsp_timeout",   64'(bus.rsp_timeout), 64'(1));
    checkOutput("to_rsp_rdata",     64'(bus.rsp_rdata),   64'(0));
    tick();

    // PREADY arriving on the last allowed ACCESS cycle completes normally
    bus.PREADY = 1'b0;
    sendCmd(1'b0, 32'h44, 32'h0, 4'h0);
    runAccess(16, accCnt, strbBad);
    checkOutput("last_access_cycles", 64'(accCnt),          64'(16));
    checkOutput("last_rsp_timeout",   64'(bus.rsp_timeout), 64'(0));
    checkOutput("last_rsp_err",       64'(bus.rsp_err),     64'(0));
    checkOutput("last_rsp_rdata",     64'(bus.rsp_rdata),   64'(32'h0BADBEEF));
    bus.PREADY = 1'b1;
    tick();

    // FIFO fill while the response slot is blocked, then in-order drain
    $display("[TB] fifo backpressure");
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b1;
    echoMode      = 1'b1;
    nAcc = 0;
    for (int i = 0; i < 16; i++) begin
      bus.cmd_valid = (nAcc < 6);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'(32'h100 + nAcc * 4);
      bus.cmd_wdata = '0;
      bus.cmd_strb  = 4'hF;
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) nAcc++;
    end
    bus.cmd_valid = 1'b0;
    checkOutput("fifo_accepts",    64'(nAcc),          64'(5));
    checkOutput("fifo_full_ready", 64'(bus.cmd_ready), 64'(0));
    checkOutput("fifo_rsp_held",   64'(bus.rsp_valid), 64'(1));
    checkOutput("fifo_fsm_idle",   64'(bus.PSEL),      64'(0));
    checkOutput("fifo_busy",       64'(bus.busy),      64'(1));
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        checkOutput($sformatf("drain_rdata_%0d", got), 64'(bus.rsp_rdata),
                    64'(32'(32'h100 + got * 4) ^ ECHO_KEY));
        got++;
      end
      tick();
    end
    checkOutput("drain_count", 64'(got), 64'(5));
    echoMode = 1'b0;

    // Reset in the middle of ACCESS
    $display("[TB] reset during access");
    bus.PREADY = 1'b0;
    sendCmd(1'b1, 32'h50, 32'h11112222, 4'h3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("mid_reach_access", 64'(seen), 64'(1));
    PRESET = 1'b1;
    tick();
    checkOutput("mid_psel",      64'(bus.PSEL),      64'(0));
    checkOutput("mid_penable",   64'(bus.PENABLE),   64'(0));
    checkOutput("mid_paddr",     64'(bus.PADDR),     64'(0));
    checkOutput("mid_pwdata",    64'(bus.PWDATA),    64'(0));
    checkOutput("mid_pstrb",     64'(bus.PSTRB),     64'(0));
    checkOutput("mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("mid_busy",      64'(bus.busy),      64'(0));
    checkOutput("mid_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    checkOutput("mid_ready_back", 64'(bus.cmd_ready), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
    end
    checkOutput("mid_no_response", 64'(seen), 64'(0));
    bus.PRDATA = 32'h600DF00D;
    sendCmd(1'b0, 32'h60, 32'h0, 4'h0);
    waitRsp("mid_new_rsp_wait", 10);
    checkOutput("mid_new_rdata", 64'(bus.rsp_rdata), 64'(32'h600DF00D));
    tick();

    // Randomized traffic, model-checked on every cycle
    $display("[TB] random traffic");
    for (int phase = 0; phase < 6; phase++) begin
      for (int i = 0; i < 500; i++) begin
        applyStimulus(biasTable[phase]);
        tick();
      end
    end
    PRESET        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.PREADY    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge PCLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Parametrised, synthesizable APB4 master that replaces task-driven bus stimulus with a queued command/response interface. Commands (address, data, strobes, direction) enter a FIFO. A SETUP/ACCESS state machine executes them one at a time on the APB bus. Each result (read data, slave error, timeout) is returned through a single-entry response register with a valid/ready handshake. The block sits between a test or CPU-side sequencer and the APB interconnect/slaves.

## Interface
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, data width; multiple of 8, range 8..64
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout
- PCLK  in  1  clock; all logic on its rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts
- rsp_err  out  1  PSLVERR was sampled high, or the transfer timed out
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PREADY  in  1  APB ready
- PRDATA  in  DATA_W  APB read data
- PSLVERR  in  1  APB slave error

## Operation
- Reset (any cycle, including mid-transfer) applies on the next edge:
  - FIFO is flushed and the FSM returns to IDLE.
  - The outstanding transfer is dropped without a response.
  - All outputs go to 0. cmd_ready goes to 1 on the first cycle after PRESET deasserts.
- Command FIFO:
  - A push occurs on `cmd_valid && cmd_ready`.
  - cmd_ready = !full, derived from a registered count of width $clog2(FIFO_DEPTH)+1.
  - When full, a command is rejected even if a pop happens in the same cycle.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when the FIFO is non-empty and (!rsp_valid || rsp_ready). PADDR, PWRITE, PWDATA and PSTRB are loaded from the FIFO head.
  - SETUP: PSEL=1, PENABLE=0; lasts exactly 1 cycle → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. The wait counter increments each cycle in which PREADY=0.
  - ACCESS with PREADY=1 → IDLE:
    - Pop the FIFO and load the response: rdata = PRDATA for a read without PSLVERR, else 0; err = PSLVERR; timeout = 0.
  - ACCESS with PREADY=0, TIMEOUT>0 and counter == TIMEOUT-1 → IDLE:
    - Pop the FIFO and load rdata=0, err=1, timeout=1.
    - PREADY=1 in the same cycle takes priority: the transfer completes normally.
- Address/control stability:
  - PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP through the end of ACCESS, and hold their last values in IDLE.
  - PSTRB is driven to 0 for reads.
  - PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.
- Response register:
  - rsp_valid is set on completion and cleared on `rsp_valid && rsp_ready`.
  - Only one transfer is ever outstanding, and no transfer starts while the response slot is occupied and not being drained. A completion therefore never overwrites an unconsumed response.

## Timing
- Latency, with the FIFO empty, IDLE, response slot free and zero wait states:
  - Command accepted at edge E0.
  - PSEL rises after E1 (SETUP).
  - PENABLE rises after E2 (ACCESS).
  - With PREADY=1, PSEL and PENABLE fall and rsp_valid rises after E3.
  - Total: 3 cycles from accept to response.
- Each PREADY=0 cycle in ACCESS adds 1 cycle.
- Maximum ACCESS length is TIMEOUT cycles.
- Throughput with rsp_ready held at 1 and PREADY at 1: one transfer per 3 cycles (SETUP, ACCESS, IDLE).
- With rsp_ready=0, the FSM stays in IDLE and the FIFO keeps accepting commands until full.

## Test plan
- Reset, then write addr 0x10, data 0xDEADBEEF, strb 0xF, with PREADY=1:
  - SETUP for 1 cycle, then ACCESS for 1 cycle.
  - PWDATA = 0xDEADBEEF throughout.
  - rsp_valid is asserted 3 cycles after accept, with rsp_err=0 and rsp_rdata=0.
- Read addr 0x20 with PREADY held low for 3 ACCESS cycles, then PRDATA = 0x12345678 with PREADY=1:
  - ACCESS lasts 4 cycles.
  - rsp_rdata = 0x12345678.
  - PSTRB = 0 during the transfer.
- Read with PSLVERR=1 and PREADY=1: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, PREADY tied low:
  - PSEL drops after exactly 16 ACCESS cycles.
  - Response has rsp_err=1 and rsp_timeout=1.
  - Repeat with PREADY=1 on cycle 16: normal completion, rsp_timeout=0.
- FIFO_DEPTH=4, rsp_ready=0, push 6 commands:
  - First transfer completes, then the FSM stays in IDLE.
  - cmd_ready falls after 5 accepts (4 queued plus 1 popped).
  - Raising rsp_ready drains all commands in order with matching responses.
- Assert PRESET during ACCESS:
  - All outputs are 0 on the next cycle and the FIFO is empty.
  - No response is produced.
  - A new command afterwards completes normally.
